// File: rtl/read_address_traversal_pkg.sv
// ============================================================================
//  Module   : read_address_traversal_pkg
//  Brief    : Address field map, count width and read FSM encodings shared
//             by the read and write address traversals.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package read_address_traversal_pkg;

   localparam int c_ba_w    = 2;
   localparam int c_col_w   = 9;
   localparam int c_row_w   = 13;
   localparam int c_cnt_w   = c_ba_w + c_col_w + c_row_w;

   localparam int c_row_lsb = 0;
   localparam int c_col_lsb = c_row_lsb + c_row_w;
   localparam int c_ba_lsb  = c_col_lsb + c_col_w;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_ADVANCE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/read_address_traversal_if.sv
// ============================================================================
//  Module   : read_address_traversal_if
//  Brief    : Request, write-count and SDRAM read-address handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface read_address_traversal_if;
   import read_address_traversal_pkg::*;

   logic                 NEXT;
   logic [c_cnt_w-1:0]   WRITE_COUNT_IN;
   logic                 ADDR_ACK;
   logic [c_ba_w-1:0]    BA_READ_OUT;
   logic [c_col_w-1:0]   COL_READ_OUT;
   logic [c_row_w-1:0]   ROW_READ_OUT;
   logic                 ADDR_VALID;
   logic                 EMPTY;
   logic                 UNDERRUN;

   modport master (
      output NEXT, WRITE_COUNT_IN, ADDR_ACK,
      input  BA_READ_OUT, COL_READ_OUT, ROW_READ_OUT, ADDR_VALID, EMPTY, UNDERRUN
   );

   modport slave (
      input  NEXT, WRITE_COUNT_IN, ADDR_ACK,
      output BA_READ_OUT, COL_READ_OUT, ROW_READ_OUT, ADDR_VALID, EMPTY, UNDERRUN
   );

endinterface

`default_nettype wire

// File: rtl/read_address_traversal_edge_sync.sv
// ============================================================================
//  Module   : edge_sync
//  Brief    : Multi-flop synchronizer followed by a one-clock rising-edge pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/read_address_traversal.sv
// ============================================================================
//  Module   : read_address_traversal
//  Brief    : Linear SDRAM read-address walker chasing the write traversal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_address_traversal
   import read_address_traversal_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = c_cnt_w
) (
   input  logic                      CLK,
   input  logic                      RESET,
   read_address_traversal_if.slave   bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_read_count;
   logic             r_pending;
   logic             r_underrun;
   logic             w_next_p;
   logic             w_empty;
   logic             w_leave_idle;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_next_sync (
      .clk     (CLK),
      .rst     (RESET),
      .i_async (bus.NEXT),
      .o_pulse (w_next_p)
   );

   assign w_empty = (r_read_count == bus.WRITE_COUNT_IN);

   always_comb begin
      w_state_nxt  = r_state;
      w_leave_idle = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pending && !w_empty) begin
               w_state_nxt  = ST_ISSUE;
               w_leave_idle = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (bus.ADDR_ACK) begin
               w_state_nxt = ST_ADVANCE;
            end
         end
         ST_ADVANCE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Count only moves in ADVANCE, so the address presented in ISSUE is stable.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_read_count <= '0;
      end else if (r_state == ST_ADVANCE) begin
         r_read_count <= r_read_count + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pending  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_next_p) begin
            r_pending <= 1'b1;
         end else if (w_leave_idle) begin
            r_pending <= 1'b0;
         end
         if (w_next_p && r_pending && w_empty) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign bus.BA_READ_OUT  = r_read_count[c_ba_lsb  +: c_ba_w];
   assign bus.COL_READ_OUT = r_read_count[c_col_lsb +: c_col_w];
   assign bus.ROW_READ_OUT = r_read_count[c_row_lsb +: c_row_w];
   assign bus.ADDR_VALID   = (r_state == ST_ISSUE);
   assign bus.EMPTY        = w_empty;
   assign bus.UNDERRUN     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_read_address_traversal.sv
// ============================================================================
//  Module   : tb_read_address_traversal
//  Brief    : Directed and randomized bench with a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_read_address_traversal;

   localparam int S = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;
   bit   preload  = 1'b0;

   read_address_traversal_if bus ();

   read_address_traversal #(
      .SYNC_STAGES (S)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: a request reaches the walker S edges after NEXT rises; one is held.
   logic [23:0] m_cnt     = '0;
   bit          m_pend    = 1'b0;
   bit          m_under   = 1'b0;
   bit          m_serving = 1'b0;
   bit          m_bump    = 1'b0;
   logic [S:0]  m_hist    = '0;

   always @(posedge clk) begin
      bit req;
      bit empty;
      if (rst) begin
         m_cnt = '0; m_pend = 0; m_under = 0; m_serving = 0; m_bump = 0;
         m_hist = '0;
      end else begin
         req   = m_hist[S-1] & ~m_hist[S];
         empty = (m_cnt == bus.WRITE_COUNT_IN);
         if (req && m_pend && empty) m_under = 1;
         if (m_bump) begin
            m_cnt  = m_cnt + 24'd1;
            m_bump = 0;
         end else if (m_serving) begin
            if (bus.ADDR_ACK) begin
               m_serving = 0;
               m_bump    = 1;
            end
         end else if (m_pend && !empty) begin
            m_serving = 1;
            m_pend    = 0;
         end
         if (req) m_pend = 1;
         if (preload) m_cnt = 24'hFFFFFF;
         m_hist = {m_hist[S-1:0], bus.NEXT};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (started) begin
         chk("valid", 32'(bus.ADDR_VALID), 32'(m_serving));
         chk("empty", 32'(bus.EMPTY), 32'(m_cnt == bus.WRITE_COUNT_IN));
         chk("underrun", 32'(bus.UNDERRUN), 32'(m_under));
         if (m_serving) begin
            chk("ba",  32'(bus.BA_READ_OUT),  32'(m_cnt) / 32'h400000);
            chk("col", 32'(bus.COL_READ_OUT), (32'(m_cnt) / 32'h2000) % 512);
            chk("row", 32'(bus.ROW_READ_OUT), 32'(m_cnt) % 8192);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic pulse_next();
      bus.NEXT = 1'b1;
      step();
      step();
      bus.NEXT = 1'b0;
      step();
      step();
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40; i++) begin
         if (bus.ADDR_VALID) break;
         step();
      end
      chk("valid_timeout", 32'(bus.ADDR_VALID), 32'd1);
   endtask

   task automatic ack();
      step();
      bus.ADDR_ACK = 1'b1;
      step();
      bus.ADDR_ACK = 1'b0;
      step();
      step();
   endtask

   initial begin
      bus.NEXT = 1'b0;
      bus.ADDR_ACK = 1'b0;
      bus.WRITE_COUNT_IN = '0;
      do_reset();
      started = 1'b1;

      chk("rst_valid", 32'(bus.ADDR_VALID), 32'd0);
      chk("rst_addr", {bus.BA_READ_OUT, bus.COL_READ_OUT, bus.ROW_READ_OUT}, 32'd0);
      chk("rst_empty", 32'(bus.EMPTY), 32'd1);
      chk("rst_underrun", 32'(bus.UNDERRUN), 32'd0);

      // Request while empty is held until write progress appears
      pulse_next();
      repeat (4) step();
      chk("empty_hold_valid", 32'(bus.ADDR_VALID), 32'd0);
      chk("empty_hold_empty", 32'(bus.EMPTY), 32'd1);
      bus.WRITE_COUNT_IN = 24'd1;
      wait_valid();
      chk("first_addr", {bus.BA_READ_OUT, bus.COL_READ_OUT, bus.ROW_READ_OUT}, 32'd0);
      ack();

      // Five reads then drained
      do_reset();
      bus.WRITE_COUNT_IN = 24'd5;
      for (int i = 0; i < 5; i++) begin
         pulse_next();
         wait_valid();
         chk("seq_row", 32'(bus.ROW_READ_OUT), 32'(i));
         ack();
      end
      chk("seq_empty", 32'(bus.EMPTY), 32'd1);

      // Stalled ISSUE with moving write count
      do_reset();
      bus.WRITE_COUNT_IN = 24'd3;
      pulse_next();
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         bus.WRITE_COUNT_IN = 24'($urandom);
         step();
         chk("stall_valid", 32'(bus.ADDR_VALID), 32'd1);
         chk("stall_row", 32'(bus.ROW_READ_OUT), 32'd0);
      end
      bus.WRITE_COUNT_IN = 24'd3;
      ack();

      // Underrun is sticky until reset
      do_reset();
      bus.WRITE_COUNT_IN = 24'd0;
      pulse_next();
      pulse_next();
      chk("underrun_set", 32'(bus.UNDERRUN), 32'd1);
      bus.WRITE_COUNT_IN = 24'd1;
      repeat (8) step();
      chk("underrun_sticky", 32'(bus.UNDERRUN), 32'd1);
      do_reset();
      chk("underrun_clr", 32'(bus.UNDERRUN), 32'd0);

      // Reset mid-ISSUE drops the request
      bus.WRITE_COUNT_IN = 24'd10;
      for (int i = 0; i < 3; i++) begin
         pulse_next();
         wait_valid();
         ack();
      end
      pulse_next();
      wait_valid();
      chk("abort_row", 32'(bus.ROW_READ_OUT), 32'd3);
      rst = 1'b1;
      step();
      chk("abort_valid", 32'(bus.ADDR_VALID), 32'd0);
      chk("abort_addr", {bus.BA_READ_OUT, bus.COL_READ_OUT, bus.ROW_READ_OUT}, 32'd0);
      chk("abort_underrun", 32'(bus.UNDERRUN), 32'd0);
      rst = 1'b0;
      repeat (6) step();
      chk("abort_no_replay", 32'(bus.ADDR_VALID), 32'd0);

      // Count wrap from the top of the address space
      do_reset();
      bus.WRITE_COUNT_IN = 24'd0;
      force dut.r_read_count = 24'hFFFFFF;
      preload = 1'b1;
      step();
      preload = 1'b0;
      release dut.r_read_count;
      step();
      chk("wrap_not_empty", 32'(bus.EMPTY), 32'd0);
      pulse_next();
      wait_valid();
      chk("wrap_ba", 32'(bus.BA_READ_OUT), 32'd3);
      chk("wrap_col", 32'(bus.COL_READ_OUT), 32'd511);
      chk("wrap_row", 32'(bus.ROW_READ_OUT), 32'd8191);
      ack();
      chk("wrap_empty", 32'(bus.EMPTY), 32'd1);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) bus.NEXT = ~bus.NEXT;
         bus.ADDR_ACK = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0)
            bus.WRITE_COUNT_IN = bus.WRITE_COUNT_IN + 24'($urandom_range(0, 2));
         step();
      end
      bus.ADDR_ACK = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
